// File: rtl/mii_tx_arbiter.sv
// Frame-level round-robin arbiter + MII nibble serializer (preamble/SFD insertion, IFG enforcement).
// Latency: grant registers on the arbitration edge, first preamble nibble on the following cycle; bytes appear 1 cycle after fetch.
// Backpressure: sources see tready only at byte-fetch slots (SFD, DATA_HI of a non-last byte) and in DRAIN; missing data aborts the frame.
module mii_tx_arbiter #(
    parameter int IFG_BYTES    = 12,
    parameter int PREAMBLE_NIB = 15
) (
    input  logic       mac_mii_tx_clk,
    input  logic       rst_n,
    input  logic [7:0] s0_tdata,
    input  logic       s0_tvalid,
    output logic       s0_tready,
    input  logic       s0_tlast,
    input  logic       s0_tuser,
    input  logic [7:0] s1_tdata,
    input  logic       s1_tvalid,
    output logic       s1_tready,
    input  logic       s1_tlast,
    input  logic       s1_tuser,
    output logic [3:0] mac_mii_txd,
    output logic       mac_mii_tx_en,
    output logic       mac_mii_tx_er,
    output logic [1:0] grant,
    output logic       underrun
);

    localparam int IFG_CYC = 2 * IFG_BYTES;
    localparam int CNT_MAX = (IFG_CYC > PREAMBLE_NIB) ? IFG_CYC : PREAMBLE_NIB;
    localparam int CW      = (CNT_MAX < 2) ? 1 : $clog2(CNT_MAX);
    localparam logic [CW-1:0] PRE_LAST = CW'(PREAMBLE_NIB - 1);
    localparam logic [CW-1:0] IFG_LAST = CW'(IFG_CYC - 1);
    localparam logic [CW-1:0] ERR_LAST = CW'(1);
    localparam bit ZERO_IFG = (IFG_CYC == 0);

    typedef enum logic [2:0] {
        IDLE, PREAMBLE, SFD, DATA_LO, DATA_HI, ERR, DRAIN, IFG
    } state_t;

    state_t        state_q;
    logic [CW-1:0] cnt_q;
    logic [1:0]    grant_q;
    logic          last_s1_q;   // 1: source 1 was granted most recently
    logic [7:0]    byte_q;
    logic          blast_q;
    logic          buser_q;
    logic [3:0]    txd_q;
    logic          tx_en_q;
    logic          tx_er_q;
    logic          underrun_q;

    logic [7:0] sel_dat;
    logic       sel_vld;
    logic       sel_last;
    logic       sel_user;
    logic       fetch;
    logic       take;
    logic       frame_end;
    logic       req_any;
    logic       arb_last_s1;
    logic [1:0] pick;
    logic       start_go;

    // Granted-source mux, fetch slots and round-robin pick
    always_comb begin
        sel_dat   = grant_q[1] ? s1_tdata  : s0_tdata;
        sel_vld   = grant_q[1] ? s1_tvalid : s0_tvalid;
        sel_last  = grant_q[1] ? s1_tlast  : s0_tlast;
        sel_user  = grant_q[1] ? s1_tuser  : s0_tuser;
        fetch     = (state_q == SFD) || (state_q == DATA_HI && !blast_q);
        take      = fetch || (state_q == DRAIN);
        frame_end = (state_q == DATA_HI && blast_q) ||
                    (state_q == DRAIN && sel_vld && sel_last);
        req_any   = s0_tvalid || s1_tvalid;
        // On a zero-gap restart the frame just finishing counts as the last grant
        arb_last_s1 = (state_q == IDLE || state_q == IFG) ? last_s1_q : grant_q[1];
        if (s0_tvalid && s1_tvalid) begin
            pick = arb_last_s1 ? 2'b01 : 2'b10;
        end else if (s0_tvalid) begin
            pick = 2'b01;
        end else begin
            pick = 2'b10;
        end
        start_go = req_any && ((state_q == IDLE) ||
                               (state_q == IFG && cnt_q == IFG_LAST) ||
                               (ZERO_IFG && frame_end));
    end

    assign s0_tready     = grant_q[0] & take;
    assign s1_tready     = grant_q[1] & take;
    assign mac_mii_txd   = txd_q;
    assign mac_mii_tx_en = tx_en_q;
    assign mac_mii_tx_er = tx_er_q;
    assign grant         = grant_q;
    assign underrun      = underrun_q;

    // Frame FSM with registered MII outputs; later statements (frame end, frame start) override the case arms
    always_ff @(posedge mac_mii_tx_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            grant_q    <= 2'b00;
            last_s1_q  <= 1'b1;
            byte_q     <= 8'h00;
            blast_q    <= 1'b0;
            buser_q    <= 1'b0;
            txd_q      <= 4'h0;
            tx_en_q    <= 1'b0;
            tx_er_q    <= 1'b0;
            underrun_q <= 1'b0;
        end else begin
            underrun_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    cnt_q <= '0;
                end
                PREAMBLE: begin
                    if (cnt_q == PRE_LAST) begin
                        state_q <= SFD;
                        txd_q   <= 4'hD;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                SFD, DATA_HI: begin
                    if (fetch) begin
                        if (sel_vld) begin
                            byte_q  <= sel_dat;
                            blast_q <= sel_last;
                            buser_q <= sel_user;
                            state_q <= DATA_LO;
                            txd_q   <= sel_dat[3:0];
                            tx_er_q <= sel_user;
                        end else begin
                            // Starved mid-frame: poison the frame on the wire
                            underrun_q <= 1'b1;
                            state_q    <= ERR;
                            cnt_q      <= '0;
                            txd_q      <= 4'h0;
                            tx_er_q    <= 1'b1;
                        end
                    end
                end
                DATA_LO: begin
                    state_q <= DATA_HI;
                    txd_q   <= byte_q[7:4];
                    tx_er_q <= buser_q;
                end
                ERR: begin
                    if (cnt_q == ERR_LAST) begin
                        state_q <= DRAIN;
                        tx_en_q <= 1'b0;
                        tx_er_q <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                DRAIN: begin
                    cnt_q <= '0;
                end
                IFG: begin
                    if (cnt_q == IFG_LAST) begin
                        state_q <= IDLE;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                default: state_q <= IDLE;
            endcase

            if (frame_end) begin
                grant_q   <= 2'b00;
                last_s1_q <= grant_q[1];
                tx_en_q   <= 1'b0;
                tx_er_q   <= 1'b0;
                txd_q     <= 4'h0;
                cnt_q     <= '0;
                state_q   <= ZERO_IFG ? IDLE : IFG;
            end

            if (start_go) begin
                grant_q <= pick;
                state_q <= PREAMBLE;
                cnt_q   <= '0;
                txd_q   <= 4'h5;
                tx_en_q <= 1'b1;
                tx_er_q <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_mii_tx_arbiter.sv
// Scoreboard bench for mii_tx_arbiter: expected nibbles queued at stimulus time, monitor pops on every active MII cycle.
// Latency: n/a (bench).
// Backpressure: source drivers honour tready, one byte per accepted handshake.
module tb_mii_tx_arbiter;

    localparam int PRE = 15;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] s0_tdata, s1_tdata;
    logic       s0_tvalid, s1_tvalid, s0_tready, s1_tready;
    logic       s0_tlast, s1_tlast, s0_tuser, s1_tuser;
    logic [3:0] txd;
    logic       tx_en, tx_er, underrun;
    logic [1:0] grant;

    logic [7:0] z_tdata, z1_tdata;
    logic       z_tvalid, z_tready, z_tlast, z_tuser;
    logic       z1_tvalid, z1_tready, z1_tlast, z1_tuser;
    logic [3:0] z_txd;
    logic       z_en, z_er, z_und;
    logic [1:0] z_grant;

    always #5 clk = ~clk;

    mii_tx_arbiter #(.IFG_BYTES(12), .PREAMBLE_NIB(PRE)) u_dut (
        .mac_mii_tx_clk(clk), .rst_n(rst_n),
        .s0_tdata(s0_tdata), .s0_tvalid(s0_tvalid), .s0_tready(s0_tready),
        .s0_tlast(s0_tlast), .s0_tuser(s0_tuser),
        .s1_tdata(s1_tdata), .s1_tvalid(s1_tvalid), .s1_tready(s1_tready),
        .s1_tlast(s1_tlast), .s1_tuser(s1_tuser),
        .mac_mii_txd(txd), .mac_mii_tx_en(tx_en), .mac_mii_tx_er(tx_er),
        .grant(grant), .underrun(underrun)
    );

    mii_tx_arbiter #(.IFG_BYTES(0), .PREAMBLE_NIB(PRE)) u_dut_zero (
        .mac_mii_tx_clk(clk), .rst_n(rst_n),
        .s0_tdata(z_tdata), .s0_tvalid(z_tvalid), .s0_tready(z_tready),
        .s0_tlast(z_tlast), .s0_tuser(z_tuser),
        .s1_tdata(z1_tdata), .s1_tvalid(z1_tvalid), .s1_tready(z1_tready),
        .s1_tlast(z1_tlast), .s1_tuser(z1_tuser),
        .mac_mii_txd(z_txd), .mac_mii_tx_en(z_en), .mac_mii_tx_er(z_er),
        .grant(z_grant), .underrun(z_und)
    );

    typedef struct packed {
        logic [1:0] g;
        logic [3:0] d;
        logic       er;
        logic       un;
    } rec_t;

    typedef struct {
        logic [7:0] d;
        logic       u;
        logic       l;
        int         stall;
    } item_t;

    rec_t  exp_q[$];
    int    gap_q[$];
    item_t stage[$];
    item_t srcq0[$];
    item_t srcq1[$];
    int    total = 0;
    int    bad   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, req, $time);
        end
    endtask

    task automatic add(input logic [7:0] d, input logic u, input logic l, input int st);
        item_t it;
        it.d = d; it.u = u; it.l = l; it.stall = st;
        stage.push_back(it);
    endtask

    // Expected wire image of the staged frame; und_at = byte index whose fetch starves
    task automatic commit(input int src, input int maxrec, input int und_at);
        logic [1:0] g;
        rec_t r[$];
        g = (src == 0) ? 2'b01 : 2'b10;
        for (int i = 0; i < PRE; i++) r.push_back({g, 4'h5, 1'b0, 1'b0});
        r.push_back({g, 4'hD, 1'b0, 1'b0});
        for (int i = 0; i < stage.size(); i++) begin
            if (i == und_at) begin
                r.push_back({g, 4'h0, 1'b1, 1'b1});
                r.push_back({g, 4'h0, 1'b1, 1'b0});
                break;
            end
            r.push_back({g, stage[i].d[3:0], stage[i].u, 1'b0});
            r.push_back({g, stage[i].d[7:4], stage[i].u, 1'b0});
        end
        for (int i = 0; i < r.size(); i++)
            if (maxrec < 0 || i < maxrec) exp_q.push_back(r[i]);
        for (int i = 0; i < stage.size(); i++)
            if (src == 0) srcq0.push_back(stage[i]); else srcq1.push_back(stage[i]);
        stage.delete();
    endtask

    task automatic wait_done(input int budget);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || srcq0.size() != 0 || srcq1.size() != 0) && n < budget) begin
            @(posedge clk);
            n++;
        end
        chk("drain_timeout", 32'(n < budget), 32'(1));
        repeat (30) @(posedge clk);
    endtask

    task automatic wait_rise(input int budget);
        int n;
        n = 0;
        @(posedge clk); #1;
        while (!tx_en && n < budget) begin
            @(posedge clk); #1;
            n++;
        end
        chk("en_rise_timeout", 32'(tx_en), 32'(1));
    endtask

    // Source drivers: pop on the handshake seen at the previous negedge, then present the next byte
    bit hs0, hs1;
    initial begin
        item_t it;
        hs0 = 1'b0; hs1 = 1'b0;
        s0_tvalid = 1'b0; s0_tdata = 8'h00; s0_tlast = 1'b0; s0_tuser = 1'b0;
        s1_tvalid = 1'b0; s1_tdata = 8'h00; s1_tlast = 1'b0; s1_tuser = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                hs0 = 1'b0; hs1 = 1'b0; s0_tvalid = 1'b0; s1_tvalid = 1'b0;
            end else begin
                if (hs0 && srcq0.size() > 0) void'(srcq0.pop_front());
                if (hs1 && srcq1.size() > 0) void'(srcq1.pop_front());
                s0_tvalid = 1'b0;
                if (srcq0.size() > 0) begin
                    it = srcq0[0];
                    if (it.stall > 0) begin
                        it.stall--; srcq0[0] = it;
                    end else begin
                        s0_tvalid = 1'b1; s0_tdata = it.d; s0_tlast = it.l; s0_tuser = it.u;
                    end
                end
                s1_tvalid = 1'b0;
                if (srcq1.size() > 0) begin
                    it = srcq1[0];
                    if (it.stall > 0) begin
                        it.stall--; srcq1[0] = it;
                    end else begin
                        s1_tvalid = 1'b1; s1_tdata = it.d; s1_tlast = it.l; s1_tuser = it.u;
                    end
                end
                hs0 = s0_tvalid & s0_tready;
                hs1 = s1_tvalid & s1_tready;
            end
        end
    end

    // Zero-gap instance source: endless 4-byte frames of an incrementing byte count
    bit z_go, z_hs;
    logic [7:0] zcnt;
    initial begin
        z_go = 1'b0; z_hs = 1'b0; zcnt = 8'h00;
        z_tvalid = 1'b0; z_tdata = 8'h00; z_tlast = 1'b0; z_tuser = 1'b0;
        z1_tvalid = 1'b0; z1_tdata = 8'h00; z1_tlast = 1'b0; z1_tuser = 1'b0;
        forever begin
            @(negedge clk);
            if (z_hs) zcnt = zcnt + 8'h01;
            z_tvalid = z_go & rst_n;
            z_tdata  = zcnt;
            z_tlast  = (zcnt[1:0] == 2'b11);
            z_hs     = z_tvalid & z_tready;
        end
    end

    // Monitor: every active MII cycle must match the next expected record; frame gaps checked when queued
    int  idle_run = 0;
    bit  prev_en  = 1'b0;
    always @(negedge clk) begin
        rec_t r;
        if (rst_n) begin
            if (tx_en || tx_er || underrun) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_nibble", 32'({grant, txd, tx_er, underrun}), 32'hFFFF);
                end else begin
                    r = exp_q.pop_front();
                    chk("nibble", 32'({grant, txd, tx_er, underrun}), 32'(r));
                end
            end
            if (tx_en && !prev_en) begin
                if (gap_q.size() > 0) chk("ifg_gap", 32'(idle_run), 32'(gap_q.pop_front()));
                idle_run = 0;
            end else if (!tx_en) begin
                idle_run++;
            end
            prev_en = tx_en;
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        logic [3:0] e;
        rst_n = 1'b0;
        #12;
        chk("reset_outputs", 32'({txd, tx_en, tx_er, grant, underrun, s0_tready, s1_tready}), 32'(0));
        @(posedge clk); #2;
        rst_n = 1'b1;
        repeat (3) @(posedge clk);

        // tuser byte marks both its nibbles, neighbours stay clean
        add(8'h11, 1'b0, 1'b0, 0); add(8'hA5, 1'b1, 1'b0, 0); add(8'h22, 1'b0, 1'b1, 0);
        commit(0, -1, -1);
        wait_done(500);

        // s1 starves before byte 3 of 6; remaining bytes are drained
        add(8'h31, 1'b0, 1'b0, 0); add(8'h32, 1'b0, 1'b0, 0); add(8'h33, 1'b0, 1'b0, 6);
        add(8'h34, 1'b0, 1'b0, 0); add(8'h35, 1'b0, 1'b0, 0); add(8'h36, 1'b0, 1'b1, 0);
        commit(1, -1, 2);
        wait_done(500);

        // Both sources always valid: strict alternation with exactly 24 idle cycles between frames
        for (int f = 0; f < 6; f++) begin
            for (int b = 1; b <= 4; b++)
                add(8'((f + 7) * 16 + b), 1'b0, 1'(b == 4), 0);
            commit(f % 2, -1, -1);
        end
        wait_rise(200);
        @(negedge clk); #1;
        for (int i = 0; i < 5; i++) gap_q.push_back(24);
        wait_done(2000);
        chk("gaps_seen", 32'(gap_q.size()), 32'(0));

        // Basic frame 01 02 03 04; leaves s0 as last grant
        add(8'h01, 1'b0, 1'b0, 0); add(8'h02, 1'b0, 1'b0, 0);
        add(8'h03, 1'b0, 1'b0, 0); add(8'h04, 1'b0, 1'b1, 0);
        commit(0, -1, -1);
        wait_done(500);

        // Reset in the 10th data nibble truncates the frame immediately
        for (int b = 1; b <= 8; b++) add(8'h40 + 8'(b), 1'b0, 1'(b == 8), 0);
        commit(0, PRE + 1 + 9, -1);
        wait_rise(200);
        repeat (PRE + 1 + 9) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_mid_outputs", 32'({txd, tx_en, tx_er, grant, underrun, s0_tready}), 32'(0));
        chk("rst_mid_nibbles_seen", 32'(exp_q.size()), 32'(0));
        repeat (3) @(posedge clk);
        srcq0.delete();
        #2;
        rst_n = 1'b1;
        // Tie right after reset: s0 must win, with no gap before its preamble
        add(8'h51, 1'b0, 1'b0, 0); add(8'h52, 1'b0, 1'b1, 0);
        commit(0, -1, -1);
        add(8'h61, 1'b0, 1'b0, 0); add(8'h62, 1'b0, 1'b1, 0);
        commit(1, -1, -1);
        n = 0;
        while (!tx_en && n < 10) begin
            @(posedge clk); #1;
            n++;
        end
        chk("start_latency_after_reset", 32'(n), 32'(1));
        wait_done(500);

        // IFG_BYTES=0 build: second preamble immediately follows last data nibble
        z_go = 1'b1;
        n = 0;
        @(posedge clk); #1;
        while (!z_en && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        chk("zero_ifg_rise", 32'(z_en), 32'(1));
        for (int i = 0; i < 48; i++) begin
            if (i > 0) begin
                @(posedge clk); #1;
            end
            if (i % 24 < PRE) e = 4'h5;
            else if (i % 24 == PRE) e = 4'hD;
            else if (((i % 24) - 16) % 2 == 0) e = 4'((i / 24) * 4 + ((i % 24) - 16) / 2);
            else e = 4'h0;
            chk("zero_ifg_nibble", 32'({z_en, z_er, z_und, z1_tready, z_grant, z_txd}),
                32'({1'b1, 1'b0, 1'b0, 1'b0, 2'b01, e}));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
